// File: rtl/ship_registry.sv
// ship_registry: per-player battleship ship table.
// Holds up to MAX_SHIPS ships of up to MAX_LEN segments (cell index + live bit),
// resolves one shot per cycle against the live segments of the active ships and
// reports hit / newly-sunk / lowest hit ship one cycle after acceptance.
module ship_registry #(
    parameter int MAX_SHIPS = 5,
    parameter int MAX_LEN   = 5,
    parameter int CELL_W    = 5,
    parameter int SHIP_W    = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic [SHIP_W-1:0]    num_ships,
    input  logic                 load_valid,
    input  logic [SHIP_W-1:0]    load_ship,
    input  logic [2:0]           load_seg,
    input  logic [CELL_W-1:0]    load_cell,
    input  logic                 start,
    input  logic                 shot_valid,
    input  logic [CELL_W-1:0]    shot_cell,
    output logic                 shot_ready,
    output logic                 resp_valid,
    output logic                 resp_hit,
    output logic                 resp_sunk,
    output logic [SHIP_W-1:0]    resp_ship,
    output logic [MAX_SHIPS-1:0] sunk_mask,
    output logic                 all_sunk,
    output logic                 start_err
);

    localparam logic [SHIP_W-1:0] SHIP_LIM = SHIP_W'(MAX_SHIPS);
    localparam logic [2:0]        SEG_LIM  = 3'(MAX_LEN);

    typedef enum logic [1:0] {
        SETUP = 2'd0,
        PLAY  = 2'd1,
        OVER  = 2'd2
    } state_t;

    state_t state, state_nx;

    // Segment storage: cells carry no reset, only the live bits decide validity.
    logic [CELL_W-1:0]                  cells [MAX_SHIPS][MAX_LEN];
    logic [MAX_SHIPS-1:0][MAX_LEN-1:0] live;
    logic [MAX_SHIPS-1:0][MAX_LEN-1:0] live_nx;
    logic [SHIP_W-1:0]                  count;
    logic [SHIP_W-1:0]                  count_nx;
    logic [MAX_SHIPS-1:0]               sunk_nx;
    logic                               start_err_nx;

    // Stage-0 (shot resolution) signals
    logic [MAX_SHIPS-1:0][MAX_LEN-1:0] wr_sel_p0;
    logic [MAX_SHIPS-1:0][MAX_LEN-1:0] live_ld_p0;
    logic [MAX_SHIPS-1:0][MAX_LEN-1:0] match_p0;
    logic [MAX_SHIPS-1:0][MAX_LEN-1:0] live_shot_p0;
    logic [MAX_SHIPS-1:0]               active_p0;
    logic [MAX_SHIPS-1:0]               hit_ships_p0;
    logic [MAX_SHIPS-1:0]               hit_low_p0;
    logic [MAX_SHIPS-1:0]               newly_sunk_p0;
    logic                               load_ok_p0;
    logic                               fire_p0;
    logic                               remaining_p0;
    logic                               start_live_p0;
    logic                               start_ok_p0;
    logic                               start_go_p0;

    // Stage-1 (response) registers
    logic                               vld_p1;
    logic                               hit_p1;
    logic                               sunk_p1;
    logic [SHIP_W-1:0]                  ship_p1;

    function automatic logic [SHIP_W-1:0] lowest_ship(input logic [MAX_SHIPS-1:0] v);
        lowest_ship = '0;
        for (int i = MAX_SHIPS - 1; i >= 0; i--) begin
            if (v[i]) lowest_ship = SHIP_W'(i);
        end
    endfunction

    // ---- stage 0: load decode, shot match, start qualification ----
    // Resolve load, shot and start against the current table contents
    always_comb begin
        load_ok_p0    = (state == SETUP) && load_valid && !clear &&
                        (load_ship < SHIP_LIM) && (load_seg < SEG_LIM);
        fire_p0       = shot_valid && shot_ready && !clear;
        wr_sel_p0     = '0;
        match_p0      = '0;
        active_p0     = '0;
        hit_ships_p0  = '0;
        newly_sunk_p0 = '0;
        remaining_p0  = 1'b0;
        start_live_p0 = 1'b0;
        for (int i = 0; i < MAX_SHIPS; i++) begin
            active_p0[i] = (SHIP_W'(i) < count);
            for (int j = 0; j < MAX_LEN; j++) begin
                wr_sel_p0[i][j] = load_ok_p0 && (load_ship == SHIP_W'(i)) && (load_seg == 3'(j));
                match_p0[i][j]  = live[i][j] && active_p0[i] && (cells[i][j] == shot_cell);
            end
        end
        // A load committed alongside start counts toward the start check.
        live_ld_p0   = live | wr_sel_p0;
        live_shot_p0 = live & ~match_p0;
        for (int i = 0; i < MAX_SHIPS; i++) begin
            hit_ships_p0[i]  = |match_p0[i];
            newly_sunk_p0[i] = (|live[i]) && !(|live_shot_p0[i]);
            if (active_p0[i] && (|live_shot_p0[i])) remaining_p0 = 1'b1;
            if ((SHIP_W'(i) < num_ships) && (|live_ld_p0[i])) start_live_p0 = 1'b1;
        end
        hit_low_p0  = hit_ships_p0 & (~hit_ships_p0 + MAX_SHIPS'(1));
        start_ok_p0 = (num_ships != '0) && (num_ships <= SHIP_LIM) && start_live_p0;
        start_go_p0 = (state == SETUP) && start && !clear && start_ok_p0;
    end

    // Next-state logic: clear dominates, start enters play, last live segment ends the game
    always_comb begin
        state_nx = state;
        if (clear) begin
            state_nx = SETUP;
        end else begin
            case (state)
                SETUP:   if (start_go_p0) state_nx = PLAY;
                PLAY:    if (fire_p0 && !remaining_p0) state_nx = OVER;
                OVER:    state_nx = OVER;
                default: state_nx = SETUP;
            endcase
        end
    end

    // Moore outputs decoded from the state
    always_comb begin
        shot_ready = (state == PLAY);
        all_sunk   = (state == OVER);
    end

    // Next values for table, latched count, sunk bitmap and start error
    always_comb begin
        live_nx = live_ld_p0;
        if (fire_p0) live_nx = live_shot_p0;
        if (clear)   live_nx = '0;
        count_nx = count;
        if (start_go_p0) count_nx = num_ships;
        if (clear)       count_nx = '0;
        // Bitmap reflects the post-update table, so it moves together with resp_valid.
        for (int i = 0; i < MAX_SHIPS; i++) begin
            sunk_nx[i] = (state_nx != SETUP) && (SHIP_W'(i) < count_nx) && !(|live_nx[i]);
        end
        start_err_nx = (state == SETUP) && start && !clear && !start_ok_p0;
    end

    // State, live bits, count and bitmap registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= SETUP;
            live      <= '0;
            count     <= '0;
            sunk_mask <= '0;
            start_err <= 1'b0;
        end else begin
            state     <= state_nx;
            live      <= live_nx;
            count     <= count_nx;
            sunk_mask <= sunk_nx;
            start_err <= start_err_nx;
        end
    end

    // Cell index storage, written only by accepted loads
    always_ff @(posedge clk) begin
        for (int i = 0; i < MAX_SHIPS; i++) begin
            for (int j = 0; j < MAX_LEN; j++) begin
                if (wr_sel_p0[i][j]) cells[i][j] <= load_cell;
            end
        end
    end

    // ---- stage 1: registered shot response ----
    // Capture the resolved shot result one cycle after acceptance
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1  <= 1'b0;
            hit_p1  <= 1'b0;
            sunk_p1 <= 1'b0;
            ship_p1 <= '0;
        end else begin
            vld_p1  <= fire_p0;
            hit_p1  <= fire_p0 && (|hit_ships_p0);
            sunk_p1 <= fire_p0 && (|(hit_low_p0 & newly_sunk_p0));
            ship_p1 <= fire_p0 ? lowest_ship(hit_ships_p0) : '0;
        end
    end

    assign resp_valid = vld_p1;
    assign resp_hit   = hit_p1;
    assign resp_sunk  = sunk_p1;
    assign resp_ship  = ship_p1;

endmodule

// File: tb/tb_ship_registry.sv
// Testbench for ship_registry: scenario tasks with a response scoreboard queue.
module tb_ship_registry;

    logic       clk;
    logic       rst;
    logic       clear;
    logic [2:0] num_ships;
    logic       load_valid;
    logic [2:0] load_ship;
    logic [2:0] load_seg;
    logic [4:0] load_cell;
    logic       start;
    logic       shot_valid;
    logic [4:0] shot_cell;
    logic       shot_ready;
    logic       resp_valid;
    logic       resp_hit;
    logic       resp_sunk;
    logic [2:0] resp_ship;
    logic [4:0] sunk_mask;
    logic       all_sunk;
    logic       start_err;

    typedef struct packed {
        logic       hit;
        logic       sunk;
        logic [2:0] ship;
    } resp_t;

    resp_t exp_q[$];
    resp_t mon_e;
    int    total = 0;
    int    bad   = 0;

    ship_registry dut (
        .clk(clk), .rst(rst), .clear(clear), .num_ships(num_ships),
        .load_valid(load_valid), .load_ship(load_ship), .load_seg(load_seg),
        .load_cell(load_cell), .start(start), .shot_valid(shot_valid),
        .shot_cell(shot_cell), .shot_ready(shot_ready), .resp_valid(resp_valid),
        .resp_hit(resp_hit), .resp_sunk(resp_sunk), .resp_ship(resp_ship),
        .sunk_mask(sunk_mask), .all_sunk(all_sunk), .start_err(start_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every response is popped against the expectation pushed at drive time
    always @(negedge clk) begin
        if (resp_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL stray_resp: got resp_valid=1 hit=%0b ship=%0d, required no response",
                         resp_hit, resp_ship);
            end else begin
                mon_e = exp_q.pop_front();
                if ({resp_hit, resp_sunk, resp_ship} !== {mon_e.hit, mon_e.sunk, mon_e.ship}) begin
                    bad++;
                    $display("FAIL resp: got hit=%0b sunk=%0b ship=%0d, required hit=%0b sunk=%0b ship=%0d",
                             resp_hit, resp_sunk, resp_ship, mon_e.hit, mon_e.sunk, mon_e.ship);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        start      = 1'b0;
        shot_valid = 1'b0;
        clear      = 1'b0;
    endtask

    task automatic load(input int s, input int g, input int c);
        load_valid = 1'b1;
        load_ship  = 3'(s);
        load_seg   = 3'(g);
        load_cell  = 5'(c);
        cyc();
    endtask

    task automatic do_start(input int n);
        num_ships = 3'(n);
        start     = 1'b1;
        cyc();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cyc();
    endtask

    task automatic fire(input int c, input logic h, input logic sk, input int s);
        resp_t e;
        e.hit  = h;
        e.sunk = sk;
        e.ship = 3'(s);
        exp_q.push_back(e);
        shot_valid = 1'b1;
        shot_cell  = 5'(c);
        cyc();
    endtask

    task automatic setup_two();
        load(0, 0, 3);
        load(0, 1, 4);
        load(1, 0, 10);
        load(1, 1, 11);
        load(1, 2, 12);
        do_start(2);
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({shot_ready, sunk_mask, all_sunk, resp_valid, start_err} !== 9'b0) begin
            bad++;
            $display("FAIL reset_state: got ready=%0b mask=%b over=%0b vld=%0b err=%0b, required all 0",
                     shot_ready, sunk_mask, all_sunk, resp_valid, start_err);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        load(0, 0, 1);
        do_start(2);
        total++;
        if ({shot_ready, sunk_mask} !== {1'b1, 5'b00010}) begin
            bad++;
            $display("FAIL reset_play: got ready=%0b mask=%b, required ready=1 mask=00010", shot_ready, sunk_mask);
        end
        #2 rst = 1'b0;
        #1;
        total++;
        if ({shot_ready, sunk_mask, all_sunk} !== 7'b0) begin
            bad++;
            $display("FAIL reset_async: got ready=%0b mask=%b over=%0b, required all 0",
                     shot_ready, sunk_mask, all_sunk);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        do_start(1);
        total++;
        if (start_err !== 1'b1) begin
            bad++;
            $display("FAIL reset_start_err: got %0b, required 1", start_err);
        end
        cyc();
        total++;
        if ({start_err, shot_ready} !== 2'b00) begin
            bad++;
            $display("FAIL reset_err_pulse: got err=%0b ready=%0b, required 0 0", start_err, shot_ready);
        end
    endtask

    task automatic test_basic();
        do_clear();
        setup_two();
        total++;
        if ({shot_ready, sunk_mask} !== {1'b1, 5'b00000}) begin
            bad++;
            $display("FAIL basic_play: got ready=%0b mask=%b, required ready=1 mask=00000", shot_ready, sunk_mask);
        end
        fire(3, 1'b1, 1'b0, 0);
        total++;
        if (sunk_mask !== 5'b00000) begin
            bad++;
            $display("FAIL basic_mask0: got %b, required 00000", sunk_mask);
        end
        fire(4, 1'b1, 1'b1, 0);
        total++;
        if ({sunk_mask, all_sunk} !== {5'b00001, 1'b0}) begin
            bad++;
            $display("FAIL basic_mask1: got mask=%b over=%0b, required mask=00001 over=0", sunk_mask, all_sunk);
        end
    endtask

    task automatic test_back_to_back();
        fire(10, 1'b1, 1'b0, 1);
        fire(11, 1'b1, 1'b0, 1);
        fire(12, 1'b1, 1'b1, 1);
        total++;
        if ({sunk_mask, all_sunk, shot_ready} !== {5'b00011, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL b2b_over: got mask=%b over=%0b ready=%0b, required mask=00011 over=1 ready=0",
                     sunk_mask, all_sunk, shot_ready);
        end
        shot_valid = 1'b1;
        shot_cell  = 5'd3;
        load_valid = 1'b1;
        load_ship  = 3'd0;
        load_seg   = 3'd0;
        load_cell  = 5'd3;
        cyc();
        cyc();
        total++;
        if ({all_sunk, sunk_mask} !== {1'b1, 5'b00011}) begin
            bad++;
            $display("FAIL over_hold: got over=%0b mask=%b, required over=1 mask=00011", all_sunk, sunk_mask);
        end
    endtask

    task automatic test_reshot();
        do_clear();
        total++;
        if ({all_sunk, sunk_mask, shot_ready} !== 7'b0) begin
            bad++;
            $display("FAIL clear_over: got over=%0b mask=%b ready=%0b, required all 0", all_sunk, sunk_mask, shot_ready);
        end
        setup_two();
        fire(3, 1'b1, 1'b0, 0);
        fire(3, 1'b0, 1'b0, 0);
        fire(0, 1'b0, 1'b0, 0);
        total++;
        if ({sunk_mask, all_sunk} !== 6'b0) begin
            bad++;
            $display("FAIL reshot_mask: got mask=%b over=%0b, required 00000 0", sunk_mask, all_sunk);
        end
    endtask

    task automatic test_duplicate();
        do_clear();
        load(0, 0, 7);
        load(1, 0, 7);
        do_start(2);
        fire(7, 1'b1, 1'b1, 0);
        total++;
        if ({sunk_mask, all_sunk, shot_ready} !== {5'b00011, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL dup: got mask=%b over=%0b ready=%0b, required mask=00011 over=1 ready=0",
                     sunk_mask, all_sunk, shot_ready);
        end
    endtask

    task automatic test_inactive_and_start();
        do_clear();
        load(0, 0, 2);
        load(1, 0, 9);
        do_start(1);
        fire(9, 1'b0, 1'b0, 0);
        fire(2, 1'b1, 1'b1, 0);
        total++;
        if ({sunk_mask, all_sunk} !== {5'b00001, 1'b1}) begin
            bad++;
            $display("FAIL inactive: got mask=%b over=%0b, required mask=00001 over=1", sunk_mask, all_sunk);
        end
        do_clear();
        load(0, 0, 2);
        do_start(0);
        total++;
        if ({start_err, shot_ready} !== 2'b10) begin
            bad++;
            $display("FAIL start_zero: got err=%0b ready=%0b, required err=1 ready=0", start_err, shot_ready);
        end
        do_start(6);
        total++;
        if ({start_err, shot_ready} !== 2'b10) begin
            bad++;
            $display("FAIL start_six: got err=%0b ready=%0b, required err=1 ready=0", start_err, shot_ready);
        end
        do_clear();
        load(5, 0, 1);
        load(0, 5, 1);
        do_start(5);
        total++;
        if ({start_err, shot_ready} !== 2'b10) begin
            bad++;
            $display("FAIL oob_load: got err=%0b ready=%0b, required err=1 ready=0", start_err, shot_ready);
        end
        load_valid = 1'b1;
        load_ship  = 3'd0;
        load_seg   = 3'd0;
        load_cell  = 5'd0;
        do_start(1);
        total++;
        if ({start_err, shot_ready, sunk_mask} !== {2'b01, 5'b00000}) begin
            bad++;
            $display("FAIL load_start: got err=%0b ready=%0b mask=%b, required err=0 ready=1 mask=00000",
                     start_err, shot_ready, sunk_mask);
        end
        fire(0, 1'b1, 1'b1, 0);
        total++;
        if (all_sunk !== 1'b1) begin
            bad++;
            $display("FAIL cell0: got over=%0b, required 1", all_sunk);
        end
    endtask

    task automatic test_rewrite();
        do_clear();
        load(2, 4, 5);
        load(2, 4, 6);
        do_start(3);
        total++;
        if (sunk_mask !== 5'b00011) begin
            bad++;
            $display("FAIL empty_sunk: got %b, required 00011", sunk_mask);
        end
        fire(5, 1'b0, 1'b0, 0);
        fire(6, 1'b1, 1'b1, 2);
        total++;
        if ({sunk_mask, all_sunk} !== {5'b00111, 1'b1}) begin
            bad++;
            $display("FAIL rewrite: got mask=%b over=%0b, required mask=00111 over=1", sunk_mask, all_sunk);
        end
    endtask

    task automatic test_clear_shot();
        do_clear();
        setup_two();
        clear      = 1'b1;
        shot_valid = 1'b1;
        shot_cell  = 5'd3;
        cyc();
        total++;
        if ({shot_ready, sunk_mask, all_sunk} !== 7'b0) begin
            bad++;
            $display("FAIL clear_shot: got ready=%0b mask=%b over=%0b, required all 0",
                     shot_ready, sunk_mask, all_sunk);
        end
        do_start(2);
        total++;
        if ({start_err, shot_ready} !== 2'b10) begin
            bad++;
            $display("FAIL clear_empty: got err=%0b ready=%0b, required err=1 ready=0", start_err, shot_ready);
        end
    endtask

    task automatic test_drain();
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 10) begin
            cyc();
            waited++;
        end
        cyc();
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("FAIL drain: got %0d pending responses, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        rst        = 1'b0;
        clear      = 1'b0;
        num_ships  = '0;
        load_valid = 1'b0;
        load_ship  = '0;
        load_seg   = '0;
        load_cell  = '0;
        start      = 1'b0;
        shot_valid = 1'b0;
        shot_cell  = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_reshot();
        test_duplicate();
        test_inactive_and_start();
        test_rewrite();
        test_clear_shot();
        test_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
